// File: rtl/nmea_pkg.sv
// Shared NMEA constants: ASCII characters, RMC header, sentence layout and
// the generator FSM state type. Also used by the RMC receive/parse block.
package nmea_pkg;

    // ASCII characters used in the sentence framing
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_A      = 8'h41;
    localparam logic [7:0] CH_V      = 8'h56;
    localparam logic [7:0] CH_ZERO   = 8'h30;

    // Talker + sentence id, first character in the top byte
    localparam logic [39:0] RMC_HDR = "GPRMC";

    // Sentence lengths in bytes, with and without the CR LF trailer
    localparam int unsigned SENT_LEN_CRLF   = 20;
    localparam int unsigned SENT_LEN_NOCRLF = 18;

    // Byte positions inside "$GPRMC,hhmmss,S*HH\r\n"
    localparam logic [4:0] IDX_SOF     = 5'd0;
    localparam logic [4:0] IDX_HDR     = 5'd1;
    localparam logic [4:0] IDX_COMMA_T = 5'd6;
    localparam logic [4:0] IDX_TIME    = 5'd7;
    localparam logic [4:0] IDX_COMMA_S = 5'd13;
    localparam logic [4:0] IDX_STATUS  = 5'd14;
    localparam logic [4:0] IDX_STAR    = 5'd15;
    localparam logic [4:0] IDX_CS_HI   = 5'd16;
    localparam logic [4:0] IDX_CS_LO   = 5'd17;
    localparam logic [4:0] IDX_CR      = 5'd18;
    localparam logic [4:0] IDX_LF      = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } rmc_state_t;

endpackage

// File: rtl/nmea_bin2ascii.sv
// 6-bit binary value (0..63) to two ASCII decimal digits, purely combinational.
module nmea_bin2ascii
    import nmea_pkg::*;
(
    input  logic [5:0] value,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [2:0] tens_bin;
    logic [5:0] rem;

    // Divide by ten with a compare ladder; the range never exceeds 63
    always_comb begin
        tens_bin = '0;
        rem      = value;
        if (value >= 6'd60) begin
            tens_bin = 3'd6;
            rem      = value - 6'd60;
        end else if (value >= 6'd50) begin
            tens_bin = 3'd5;
            rem      = value - 6'd50;
        end else if (value >= 6'd40) begin
            tens_bin = 3'd4;
            rem      = value - 6'd40;
        end else if (value >= 6'd30) begin
            tens_bin = 3'd3;
            rem      = value - 6'd30;
        end else if (value >= 6'd20) begin
            tens_bin = 3'd2;
            rem      = value - 6'd20;
        end else if (value >= 6'd10) begin
            tens_bin = 3'd1;
            rem      = value - 6'd10;
        end
    end

    assign tens = CH_ZERO + {5'd0, tens_bin};
    assign ones = CH_ZERO + {2'd0, rem};

endmodule

// File: rtl/nmea_rmc_gen.sv
// NMEA $GPRMC time sentence generator: "$GPRMC,hhmmss,S*HH\r\n", streamed one
// byte per valid/ready handshake. Output bytes and status are registered.
module nmea_rmc_gen
    import nmea_pkg::*;
#(
    parameter int CHECK_RANGE = 1,
    parameter int EMIT_CRLF   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] hr,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       fix_ok,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_IDX = (EMIT_CRLF != 0) ? 5'(SENT_LEN_CRLF - 1)
                                                       : 5'(SENT_LEN_NOCRLF - 1);

    rmc_state_t state;

    logic [4:0] hold_hr;
    logic [5:0] hold_min;
    logic [5:0] hold_sec;
    logic       hold_fix;

    logic [7:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
    logic [7:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic [7:0] status_ch;
    logic [7:0] status_nxt;
    logic [7:0] cs;
    logic [4:0] idx;
    logic [4:0] idx_nxt;
    logic [7:0] next_byte;
    logic       in_range;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        hex_ascii = (nib < 4'd10) ? (CH_ZERO + {4'd0, nib}) : (8'h37 + {4'd0, nib});
    endfunction

    nmea_bin2ascii u_hr  (.value({1'b0, hold_hr}), .tens(hr_tens),  .ones(hr_ones));
    nmea_bin2ascii u_min (.value(hold_min),        .tens(min_tens), .ones(min_ones));
    nmea_bin2ascii u_sec (.value(hold_sec),        .tens(sec_tens), .ones(sec_ones));

    // Status character: fix flag, optionally vetoed by an out-of-range time
    always_comb begin
        in_range   = (hold_hr <= 5'd23) && (hold_min <= 6'd59) && (hold_sec <= 6'd59);
        status_nxt = (hold_fix && (in_range || (CHECK_RANGE == 0))) ? CH_A : CH_V;
    end

    // Byte to present after the current one is accepted; checksum nibbles
    // read the register, which is final once the status byte has gone out
    always_comb begin
        idx_nxt   = idx + 5'd1;
        next_byte = '0;
        case (idx_nxt)
            IDX_HDR:            next_byte = RMC_HDR[39:32];
            IDX_HDR + 5'd1:     next_byte = RMC_HDR[31:24];
            IDX_HDR + 5'd2:     next_byte = RMC_HDR[23:16];
            IDX_HDR + 5'd3:     next_byte = RMC_HDR[15:8];
            IDX_HDR + 5'd4:     next_byte = RMC_HDR[7:0];
            IDX_COMMA_T:        next_byte = CH_COMMA;
            IDX_TIME:           next_byte = hr_t;
            IDX_TIME + 5'd1:    next_byte = hr_o;
            IDX_TIME + 5'd2:    next_byte = min_t;
            IDX_TIME + 5'd3:    next_byte = min_o;
            IDX_TIME + 5'd4:    next_byte = sec_t;
            IDX_TIME + 5'd5:    next_byte = sec_o;
            IDX_COMMA_S:        next_byte = CH_COMMA;
            IDX_STATUS:         next_byte = status_ch;
            IDX_STAR:           next_byte = CH_STAR;
            IDX_CS_HI:          next_byte = hex_ascii(cs[7:4]);
            IDX_CS_LO:          next_byte = hex_ascii(cs[3:0]);
            IDX_CR:             next_byte = CH_CR;
            IDX_LF:             next_byte = CH_LF;
            default:            next_byte = '0;
        endcase
    end

    // Sentence FSM with registered stream outputs and running XOR checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_hr   <= '0;
            hold_min  <= '0;
            hold_sec  <= '0;
            hold_fix  <= 1'b0;
            hr_t      <= '0;
            hr_o      <= '0;
            min_t     <= '0;
            min_o     <= '0;
            sec_t     <= '0;
            sec_o     <= '0;
            status_ch <= '0;
            cs        <= '0;
            idx       <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        hold_hr  <= hr;
                        hold_min <= min;
                        hold_sec <= sec;
                        hold_fix <= fix_ok;
                        busy     <= 1'b1;
                        state    <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    hr_t      <= hr_tens;
                    hr_o      <= hr_ones;
                    min_t     <= min_tens;
                    min_o     <= min_ones;
                    sec_t     <= sec_tens;
                    sec_o     <= sec_ones;
                    status_ch <= status_nxt;
                    cs        <= '0;
                    idx       <= IDX_SOF;
                    tx_data   <= CH_DOLLAR;
                    tx_valid  <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_valid && tx_ready) begin
                        if ((idx >= IDX_HDR) && (idx <= IDX_STATUS)) begin
                            cs <= cs ^ tx_data;
                        end
                        if (idx == LAST_IDX) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            idx     <= idx_nxt;
                            tx_data <= next_byte;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmea_rmc_gen.sv
// Directed bench for nmea_rmc_gen: hand-computed sentences, latency,
// backpressure stability, range check, ignored starts and mid-sentence reset.
module tb_nmea_rmc_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] hr = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic       fix_ok = 1'b0;
    logic       tx_ready = 1'b0;

    logic [7:0] tx_data, tx_data_nr;
    logic       tx_valid, tx_valid_nr;
    logic       busy, busy_nr;
    logic       done, done_nr;

    int passes = 0;
    int total  = 0;

    logic [7:0] got[$];
    int done_cnt;
    int dollar_cyc;
    int done_cyc;

    nmea_rmc_gen #(.CHECK_RANGE(1), .EMIT_CRLF(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hr(hr), .min(min), .sec(sec),
        .fix_ok(fix_ok), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    nmea_rmc_gen #(.CHECK_RANGE(0), .EMIT_CRLF(1)) dut_nr (
        .clk(clk), .rst_n(rst_n), .start(start), .hr(hr), .min(min), .sec(sec),
        .fix_ok(fix_ok), .tx_data(tx_data_nr), .tx_valid(tx_valid_nr), .tx_ready(tx_ready),
        .busy(busy_nr), .done(done_nr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Runs one sentence from the current cycle and records accepted bytes.
    task automatic run(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                       input logic f, input bit bp, input int repulse_at,
                       input int abort_at, input bit start_on_done, input bit use_nr);
        logic       v, dn, rdy, prev_stall;
        logic [7:0] d, prev_d;
        bit         rep, sod_fired, sod_check;
        int         cyc;
        hr = h; min = m; sec = s; fix_ok = f;
        got.delete();
        done_cnt = 0; dollar_cyc = -1; done_cyc = -1;
        rep = 0; sod_fired = 0; sod_check = 0; prev_stall = 0; prev_d = '0;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        for (int n = 0; n < 400; n++) begin
            start = 1'b0;
            v  = use_nr ? tx_valid_nr : tx_valid;
            d  = use_nr ? tx_data_nr  : tx_data;
            dn = use_nr ? done_nr     : done;
            if (prev_stall) begin
                check("stall_data", d, prev_d);
                check("stall_valid", v, 1);
            end else if (got.size() > 0 && got.size() < 20) begin
                check($sformatf("valid_mid%0d", got.size()), v, 1);
            end
            if (sod_check) begin
                check("start_on_done_busy", use_nr ? busy_nr : busy, 0);
                sod_check = 0;
            end
            if (dn) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (start_on_done && !sod_fired) begin
                    start = 1'b1; sod_fired = 1; sod_check = 1;
                end
            end
            if (v && got.size() == 0 && dollar_cyc < 0) dollar_cyc = cyc;
            if (abort_at >= 0 && v && got.size() == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", tx_valid, 0);
                check("abort_busy", busy, 0);
                #2 rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check("abort_no_done", done, 0);
                    check("abort_idle_valid", tx_valid, 0);
                end
                return;
            end
            if (repulse_at >= 0 && v && got.size() == repulse_at && !rep) begin
                start = 1'b1; hr = 5'd3; min = 6'd7; sec = 6'd9; fix_ok = 1'b0; rep = 1;
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_ready = rdy;
            if (v && rdy) got.push_back(d);
            prev_stall = v && !rdy;
            prev_d = d;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("done_once", done_cnt, 1);
    endtask

    // Compares the captured stream against "<body>\r\n"
    task automatic verify(input string tag, input string body);
        logic [7:0] obs;
        logic [7:0] exp;
        check({tag, "_len"}, got.size(), 20);
        for (int i = 0; i < 20; i++) begin
            obs = (i < got.size()) ? got[i] : 8'h00;
            if (i < 18) exp = body[i];
            else exp = (i == 18) ? 8'h0D : 8'h0A;
            check($sformatf("%s_byte%0d", tag, i), obs, exp);
        end
    endtask

    // Loopback decode of the time field, as the parser would do
    task automatic loopback(input string tag, input int h, input int m, input int s);
        int vh, vm, vs;
        vh = (int'(got[7])  - 48) * 10 + (int'(got[8])  - 48);
        vm = (int'(got[9])  - 48) * 10 + (int'(got[10]) - 48);
        vs = (int'(got[11]) - 48) * 10 + (int'(got[12]) - 48);
        check({tag, "_hr"}, vh, h);
        check({tag, "_min"}, vm, m);
        check({tag, "_sec"}, vs, s);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sentence with latency
        run(5'd12, 6'd34, 6'd56, 1'b1, 0, -1, -1, 0, 0);
        verify("c1", "$GPRMC,123456,A*0D");
        check("c1_dollar_cyc", dollar_cyc, 2);
        check("c1_done_cyc", done_cyc, 22);
        loopback("c1", 12, 34, 56);

        // Boundary times
        run(5'd0, 6'd0, 6'd0, 1'b0, 0, -1, -1, 0, 0);
        verify("c2a", "$GPRMC,000000,V*1D");
        run(5'd23, 6'd59, 6'd59, 1'b1, 0, -1, -1, 1, 0);
        verify("c2b", "$GPRMC,235959,A*0B");

        // Random backpressure
        run(5'd12, 6'd34, 6'd56, 1'b1, 1, -1, -1, 0, 0);
        verify("c3", "$GPRMC,123456,A*0D");

        // Range check on and off
        run(5'd24, 6'd10, 6'd5, 1'b1, 0, -1, -1, 0, 0);
        verify("c4a", "$GPRMC,241005,V*1F");
        run(5'd24, 6'd10, 6'd5, 1'b1, 0, -1, -1, 0, 1);
        verify("c4b", "$GPRMC,241005,A*08");
        run(5'd5, 6'd63, 6'd0, 1'b1, 0, -1, -1, 0, 0);
        verify("c4c", "$GPRMC,056300,V*1D");

        // Start re-pulsed mid-sentence
        run(5'd12, 6'd34, 6'd56, 1'b1, 0, 8, -1, 0, 0);
        verify("c5", "$GPRMC,123456,A*0D");
        check("c5_busy_after", busy, 0);
        check("c5_valid_after", tx_valid, 0);

        // Reset mid-sentence, then a clean sentence
        run(5'd12, 6'd34, 6'd56, 1'b1, 0, -1, 10, 0, 0);
        @(posedge clk); #1;
        run(5'd9, 6'd41, 6'd30, 1'b1, 0, -1, -1, 0, 0);
        verify("c6", "$GPRMC,094130,A*05");
        loopback("c6", 9, 41, 30);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
